// File: rtl/seven_seg_pkg.sv
// Shared types, constants and the BCD to 7-segment table for the scanned display.
package seven_seg_pkg;

    // Segment bus as driven on the pins: {dp, g, f, e, d, c, b, a}, all active-low.
    typedef struct packed {
        logic       dp;
        logic [6:0] segs;
    } segVec_t;

    localparam segVec_t    SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    // Codes A-F have no BCD meaning and are shown dark.
    function automatic logic [6:0] seg7Encode(input logic [3:0] bcd);
        logic [6:0] code;
        case (bcd)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-slot prescaler and digit index for the scan controller; reports the anti-ghost
// guard window and the first cycle of each frame.
module seg_scan_timer #(
    parameter  int NUM_DIGITS   = 4,
    parameter  int SCAN_DIV     = 50000,
    parameter  int BLANK_CYCLES = 16,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int DIV_W        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             guard_o,
    output logic             frameTick_o
);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Disabled means parked at the start of slot 0, so re-enabling begins a fresh frame.
    always_comb begin
        divCnt_d = divCnt_q;
        idx_d    = idx_q;
        if (!enable_i) begin
            divCnt_d = '0;
            idx_d    = '0;
        end else if (divCnt_q == DIV_MAX) begin
            divCnt_d = '0;
            idx_d    = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end else begin
            divCnt_d = divCnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            divCnt_q <= '0;
            idx_q    <= '0;
        end else begin
            divCnt_q <= divCnt_d;
            idx_q    <= idx_d;
        end
    end

    assign idx_o       = idx_q;
    assign guard_o     = int'(divCnt_q) < BLANK_CYCLES;
    assign frameTick_o = enable_i && (divCnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexes NUM_DIGITS BCD digits onto one common-anode 7-segment bus, with a
// double-buffered valid/ready load port whose values take effect on frame boundaries.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int SCAN_DIV     = 50000,
    parameter  int BLANK_CYCLES = 16,
    parameter  int LZ_BLANK     = 1,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [4*NUM_DIGITS-1:0] load_digits_i,
    input  logic [NUM_DIGITS-1:0]   load_dots_i,
    output logic [7:0]              seg_n_o,
    output logic [NUM_DIGITS-1:0]   an_n_o,
    output logic [IDX_W-1:0]        digit_idx_o,
    output logic                    frame_start_o
);

    logic [IDX_W-1:0] idx;
    logic             guard;
    logic             frameTick;

    seg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .idx_o      (idx),
        .guard_o    (guard),
        .frameTick_o(frameTick)
    );

    logic [NUM_DIGITS-1:0][3:0] activeDigits_q, activeDigits_d;
    logic [NUM_DIGITS-1:0][3:0] pendDigits_q, pendDigits_d;
    logic [NUM_DIGITS-1:0]      activeDots_q, activeDots_d;
    logic [NUM_DIGITS-1:0]      pendDots_q, pendDots_d;
    logic                       pendFull_q, pendFull_d;
    logic [NUM_DIGITS-1:0]      anN_q, anN_d;
    segVec_t                    segN_q, segN_d;
    logic                       frameStart_q, frameStart_d;
    logic [IDX_W-1:0]           digitIdx_q, digitIdx_d;
    logic                       commit;
    logic                       accept;
    logic [NUM_DIGITS-1:0]      lzBlank;
    logic                       higherZero;

    // The frame boundary is the cycle frame_start is visible, so a source watching that
    // pulse can hand over its next value in the same cycle the old one is committed.
    assign commit       = pendFull_q && (!enable_i || frameStart_q);
    assign load_ready_o = !pendFull_q || commit;
    assign accept       = load_valid_i && load_ready_o;

    always_comb begin
        pendDigits_d   = pendDigits_q;
        pendDots_d     = pendDots_q;
        activeDigits_d = activeDigits_q;
        activeDots_d   = activeDots_q;
        if (accept) begin
            pendDigits_d = load_digits_i;
            pendDots_d   = load_dots_i;
        end
        if (commit) begin
            activeDigits_d = pendDigits_q;
            activeDots_d   = pendDots_q;
        end
        pendFull_d = accept || (pendFull_q && !commit);
    end

    // Digit i>0 goes dark when it and every more significant digit are zero.
    always_comb begin
        lzBlank    = '0;
        higherZero = 1'b1;
        if (LZ_BLANK != 0) begin
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                higherZero = higherZero && (activeDigits_d[i] == 4'd0);
                lzBlank[i] = higherZero;
            end
        end
    end

    always_comb begin
        anN_d        = '1;
        segN_d       = SEG_BLANK;
        frameStart_d = frameTick;
        digitIdx_d   = '0;
        if (enable_i) begin
            digitIdx_d  = idx;
            if (!guard) begin
                anN_d[idx] = 1'b0;
            end
            segN_d.dp   = ~activeDots_d[idx];
            segN_d.segs = lzBlank[idx] ? SEG_OFF : seg7Encode(activeDigits_d[idx]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            activeDigits_q <= '0;
            activeDots_q   <= '0;
            pendDigits_q   <= '0;
            pendDots_q     <= '0;
            pendFull_q     <= 1'b0;
            anN_q          <= '1;
            segN_q         <= SEG_BLANK;
            frameStart_q   <= 1'b0;
            digitIdx_q     <= '0;
        end else begin
            activeDigits_q <= activeDigits_d;
            activeDots_q   <= activeDots_d;
            pendDigits_q   <= pendDigits_d;
            pendDots_q     <= pendDots_d;
            pendFull_q     <= pendFull_d;
            anN_q          <= anN_d;
            segN_q         <= segN_d;
            frameStart_q   <= frameStart_d;
            digitIdx_q     <= digitIdx_d;
        end
    end

    assign an_n_o        = anN_q;
    assign seg_n_o       = segN_q;
    assign frame_start_o = frameStart_q;
    assign digit_idx_o   = digitIdx_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with 4 digits, 8-cycle slots, 2-cycle guard and
// leading-zero blanking; offsets are counted in clocks from the last visible frame_start.
module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        loadValid;
    logic        loadReady;
    logic [15:0] loadDigits;
    logic [3:0]  loadDots;
    logic [7:0]  segN;
    logic [3:0]  anN;
    logic [1:0]  digitIdx;
    logic        frameStart;

    int numCompared   = 0;
    int numMismatched = 0;
    int off           = 0;

    localparam logic [15:0] AN_EXP = 16'h7BDE;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2),
        .LZ_BLANK    (1)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .load_valid_i (loadValid),
        .load_ready_o (loadReady),
        .load_digits_i(loadDigits),
        .load_dots_i  (loadDots),
        .seg_n_o      (segN),
        .an_n_o       (anN),
        .digit_idx_o  (digitIdx),
        .frame_start_o(frameStart)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numCompared++;
        if (actual !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    task automatic goTo(input int target);
        while (off < target) begin
            @(negedge clk);
            off++;
        end
    endtask

    task automatic waitFrame(input string tag);
        int n = 0;
        while (frameStart !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, frameStart, 1);
        off = 0;
    endtask

    // One-cycle load; the port is expected to be free when this is called.
    task automatic applyStimulus(input string tag, input logic [15:0] digits, input logic [3:0] dots);
        loadValid  = 1'b1;
        loadDigits = digits;
        loadDots   = dots;
        checkOutput({tag, "_ready"}, loadReady, 1);
        @(negedge clk);
        off++;
        loadValid = 1'b0;
    endtask

    // Samples mid-slot of each digit; segs packs the expected seg_n with digit 0 lowest.
    task automatic checkFrame(input string tag, input logic [31:0] segs);
        for (int s = 0; s < 4; s++) begin
            goTo(8 * s + 4);
            checkOutput($sformatf("%s_seg%0d", tag, s), segN, segs[8*s +: 8]);
            checkOutput($sformatf("%s_an%0d", tag, s), anN, AN_EXP[4*s +: 4]);
        end
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        enable     = 1'b0;
        loadValid  = 1'b0;
        loadDigits = '0;
        loadDots   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_an", anN, 4'hF);
        checkOutput("rst_seg", segN, 8'hFF);
        checkOutput("rst_fs", frameStart, 0);
        checkOutput("rst_ready", loadReady, 1);
        checkOutput("rst_idx", digitIdx, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("dis_an", anN, 4'hF);

        // Scan sequence straight out of reset with all-zero digits.
        enable = 1'b1;
        @(negedge clk);
        checkOutput("en_fs", frameStart, 1);
        off = 0;
        goTo(1);  checkOutput("scan_an1", anN, 4'hF);
        goTo(2);  checkOutput("scan_an2", anN, 4'hE);
                  checkOutput("scan_seg2", segN, 8'hC0);
        goTo(7);  checkOutput("scan_an7", anN, 4'hE);
        goTo(8);  checkOutput("scan_an8", anN, 4'hF);
        goTo(10); checkOutput("scan_an10", anN, 4'hD);
                  checkOutput("scan_idx10", digitIdx, 1);
                  checkOutput("scan_seg10", segN, 8'hFF);
        goTo(26); checkOutput("scan_an26", anN, 4'h7);
        goTo(31); checkOutput("scan_fs31", frameStart, 0);
        goTo(32); checkOutput("scan_fs32", frameStart, 1);

        // Plain digit encoding with one decimal point.
        applyStimulus("ld1234", 16'h1234, 4'b0100);
        waitFrame("ld1234_frame");
        checkFrame("ld1234", 32'hF924B099);

        // Leading zeros above a nonzero digit go dark, digit 0 never does.
        applyStimulus("ld0070", 16'h0070, 4'b0000);
        waitFrame("ld0070_frame");
        checkFrame("ld0070", 32'hFFFFF8C0);

        // Second load waits for the frame boundary while the first is pending.
        waitFrame("bufA_start");
        goTo(3);
        applyStimulus("bufA", 16'h5678, 4'b0001);
        loadValid  = 1'b1;
        loadDigits = 16'h0042;
        loadDots   = 4'b0000;
        checkOutput("bufB_busy", loadReady, 0);
        n = 0;
        while (loadReady !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bufB_ready", loadReady, 1);
        checkOutput("bufB_fsSame", frameStart, 1);
        off = 0;
        @(negedge clk);
        off++;
        loadValid = 1'b0;
        checkOutput("bufB_held", loadReady, 0);
        checkFrame("bufA", 32'h9282F800);
        waitFrame("bufB_frame");
        checkFrame("bufB", 32'hFFFF99A4);

        // Disabled: a load commits at once and the display stays dark.
        enable     = 1'b0;
        loadValid  = 1'b1;
        loadDigits = 16'h9999;
        loadDots   = 4'b0000;
        checkOutput("dis_ready", loadReady, 1);
        @(negedge clk);
        loadValid = 1'b0;
        @(negedge clk);
        checkOutput("dis2_an", anN, 4'hF);
        checkOutput("dis2_seg", segN, 8'hFF);
        checkOutput("dis2_fs", frameStart, 0);
        checkOutput("dis2_idx", digitIdx, 0);
        enable = 1'b1;
        @(negedge clk);
        checkOutput("reen_fs", frameStart, 1);
        off = 0;
        goTo(1);  checkOutput("reen_an1", anN, 4'hF);
        goTo(4);  checkOutput("reen_seg4", segN, 8'h90);
                  checkOutput("reen_an4", anN, 4'hE);
        goTo(12); checkOutput("reen_seg12", segN, 8'h90);

        // Reset mid-slot discards a pending load.
        goTo(21);
        applyStimulus("rstLd", 16'h1111, 4'b1111);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mrst_an", anN, 4'hF);
        checkOutput("mrst_seg", segN, 8'hFF);
        checkOutput("mrst_ready", loadReady, 1);
        checkOutput("mrst_fs", frameStart, 0);
        reset = 1'b0;
        waitFrame("postRst_frame");
        checkFrame("postRst", 32'hFFFFFFC0);
        waitFrame("postRst2_frame");
        goTo(4);
        checkOutput("postRst2_seg0", segN, 8'hC0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
